// File: rtl/spike_rate_encoder.sv
// ---------------------------------------------------------------------------
// spike_rate_encoder
//
// Converts an 8-bit grayscale image held in a pixel RAM into a stochastic
// rate-coded spike train.  For every timestep each pixel is compared against
// the low byte of a free-running 16-bit Galois LFSR.  A pixel spikes when it
// is strictly larger.  Spikes are packed LSB-first, DATA_W per word, and
// written to a spike RAM.  The output is laid out as num_steps consecutive
// frames of W = ceil(N/DATA_W) words each.
//
// Ports
//   clk                 rising-edge clock
//   reset               asynchronous active-high reset, clears all state
//   start               one-cycle request, sampled only while idle
//   done                one-cycle pulse when encoding completes
//   busy                high from the accepted start until done
//   row_size, col_size  image dimensions (latched at start)
//   num_steps           number of timesteps to generate (latched at start)
//   seed                LFSR seed, 0 selects 16'hACE1 (latched at start)
//   src_start_address   pixel region base (latched at start)
//   dest_start_address  spike region base (latched at start)
//   src_address         pixel RAM read address, data valid one cycle later
//   src_readdata        pixel RAM word, pixel in bits [7:0]
//   dest_address        spike RAM write address
//   dest_writedata      packed spike word
//   dest_write_en       one-cycle write strobe
// ---------------------------------------------------------------------------
module spike_rate_encoder #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              done,
    output logic              busy,
    input  logic [5:0]        row_size,
    input  logic [5:0]        col_size,
    input  logic [3:0]        num_steps,
    input  logic [15:0]       seed,
    input  logic [ADDR_W-1:0] src_start_address,
    input  logic [ADDR_W-1:0] dest_start_address,
    output logic [ADDR_W-1:0] src_address,
    input  logic [DATA_W-1:0] src_readdata,
    output logic [ADDR_W-1:0] dest_address,
    output logic [DATA_W-1:0] dest_writedata,
    output logic              dest_write_en
);

    localparam int          IDX_W        = $clog2(DATA_W);
    localparam logic [15:0] LFSR_MASK    = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_CMP   = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        lfsr_step = {1'b0, v[15:1]} ^ (v[0] ? LFSR_MASK : 16'h0000);
    endfunction

    logic [2:0]        state_r;
    logic [11:0]       n_r;
    logic [11:0]       words_r;
    logic [3:0]        steps_r;
    logic [ADDR_W-1:0] src_base_r;
    logic [ADDR_W-1:0] dest_base_r;
    logic [11:0]       p_r;
    logic [3:0]        t_r;
    logic [11:0]       w_r;
    logic [DATA_W-1:0] pack_r;
    logic [15:0]       lfsr_r;

    logic              done_r;
    logic              busy_r;
    logic [ADDR_W-1:0] src_address_r;
    logic [ADDR_W-1:0] dest_address_r;
    logic [DATA_W-1:0] dest_writedata_r;
    logic              dest_write_en_r;

    logic [11:0]       n_in_s;
    logic [11:0]       words_in_s;
    logic [IDX_W-1:0]  idx_s;
    logic              spike_s;
    logic [DATA_W-1:0] pack_next_s;
    logic              word_full_s;
    logic              last_pix_s;
    logic              last_step_s;
    logic [15:0]       frame_off_s;
    logic [ADDR_W-1:0] dest_addr_s;
    logic              unused_hi_s;

    assign done           = done_r;
    assign busy           = busy_r;
    assign src_address    = src_address_r;
    assign dest_address   = dest_address_r;
    assign dest_writedata = dest_writedata_r;
    assign dest_write_en  = dest_write_en_r;

    // Only the low byte of a pixel word carries data.
    assign unused_hi_s = &{1'b0, src_readdata[DATA_W-1:8]};

    // Datapath: image size, packing position, spike decision and write address.
    always_comb begin
        n_in_s      = {6'd0, row_size} * {6'd0, col_size};
        words_in_s  = 12'((13'(n_in_s) + 13'(DATA_W - 1)) >> IDX_W);
        idx_s       = p_r[IDX_W-1:0];
        spike_s     = (src_readdata[7:0] > lfsr_r[7:0]);
        pack_next_s = pack_r;
        pack_next_s[idx_s] = spike_s;
        word_full_s = (idx_s == IDX_W'(DATA_W - 1));
        last_pix_s  = (p_r == (n_r - 12'd1));
        last_step_s = (t_r == (steps_r - 4'd1));
        frame_off_s = {12'd0, t_r} * {4'd0, words_r};
        dest_addr_s = dest_base_r + ADDR_W'(frame_off_s) + ADDR_W'(w_r);
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r          <= S_IDLE;
            n_r              <= 12'd0;
            words_r          <= 12'd0;
            steps_r          <= 4'd0;
            src_base_r       <= '0;
            dest_base_r      <= '0;
            p_r              <= 12'd0;
            t_r              <= 4'd0;
            w_r              <= 12'd0;
            pack_r           <= '0;
            lfsr_r           <= LFSR_DEFAULT;
            done_r           <= 1'b0;
            busy_r           <= 1'b0;
            src_address_r    <= '0;
            dest_address_r   <= '0;
            dest_writedata_r <= '0;
            dest_write_en_r  <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    done_r          <= 1'b0;
                    dest_write_en_r <= 1'b0;
                    if (start) begin
                        n_r         <= n_in_s;
                        words_r     <= words_in_s;
                        steps_r     <= num_steps;
                        src_base_r  <= src_start_address;
                        dest_base_r <= dest_start_address;
                        lfsr_r      <= (seed == 16'h0000) ? LFSR_DEFAULT : seed;
                        p_r         <= 12'd0;
                        t_r         <= 4'd0;
                        w_r         <= 12'd0;
                        pack_r      <= '0;
                        // An empty job finishes without touching either RAM.
                        if ((num_steps == 4'd0) || (n_in_s == 12'd0)) begin
                            state_r <= S_DONE;
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r       <= S_READ;
                            busy_r        <= 1'b1;
                            src_address_r <= src_start_address;
                        end
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_READ: begin
                    state_r <= S_WAIT;
                end
                S_WAIT: begin
                    state_r <= S_CMP;
                end
                S_CMP: begin
                    pack_r <= pack_next_s;
                    lfsr_r <= lfsr_step(lfsr_r);
                    if (word_full_s || last_pix_s) begin
                        state_r          <= S_WRITE;
                        dest_write_en_r  <= 1'b1;
                        dest_writedata_r <= pack_next_s;
                        dest_address_r   <= dest_addr_s;
                    end else begin
                        state_r       <= S_READ;
                        p_r           <= p_r + 12'd1;
                        src_address_r <= src_base_r + ADDR_W'(p_r + 12'd1);
                    end
                end
                S_WRITE: begin
                    dest_write_en_r <= 1'b0;
                    pack_r          <= '0;
                    if (!last_pix_s) begin
                        state_r       <= S_READ;
                        p_r           <= p_r + 12'd1;
                        w_r           <= w_r + 12'd1;
                        src_address_r <= src_base_r + ADDR_W'(p_r + 12'd1);
                    end else if (!last_step_s) begin
                        // Next frame: LFSR keeps running, it is not reseeded.
                        state_r       <= S_READ;
                        p_r           <= 12'd0;
                        w_r           <= 12'd0;
                        t_r           <= t_r + 4'd1;
                        src_address_r <= src_base_r;
                    end else begin
                        state_r <= S_DONE;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                    end
                end
                S_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r         <= S_IDLE;
                    done_r          <= 1'b0;
                    busy_r          <= 1'b0;
                    dest_write_en_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spike_rate_encoder.sv
// ---------------------------------------------------------------------------
// tb_spike_rate_encoder
//
// Directed bench for spike_rate_encoder: a synchronous pixel RAM model feeds
// the DUT, a negedge monitor collects every spike-RAM write and done pulse,
// and a reference LFSR/encoder model produces the expected write stream.
// ---------------------------------------------------------------------------
module tb_spike_rate_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        done;
    logic        busy;
    logic [5:0]  row_size;
    logic [5:0]  col_size;
    logic [3:0]  num_steps;
    logic [15:0] seed;
    logic [11:0] src_start_address;
    logic [11:0] dest_start_address;
    logic [11:0] src_address;
    logic [15:0] src_readdata;
    logic [11:0] dest_address;
    logic [15:0] dest_writedata;
    logic        dest_write_en;

    logic [15:0] src_mem [0:4095];

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;
    int start_cyc = 0;
    int done_cyc  = 0;
    int last_wr_cyc = 0;
    int done_cnt  = 0;

    int wr_addr_q[$];
    int wr_data_q[$];
    int exp_addr_q[$];
    int exp_data_q[$];

    spike_rate_encoder #(.ADDR_W(12), .DATA_W(16)) dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .done               (done),
        .busy               (busy),
        .row_size           (row_size),
        .col_size           (col_size),
        .num_steps          (num_steps),
        .seed               (seed),
        .src_start_address  (src_start_address),
        .dest_start_address (dest_start_address),
        .src_address        (src_address),
        .src_readdata       (src_readdata),
        .dest_address       (dest_address),
        .dest_writedata     (dest_writedata),
        .dest_write_en      (dest_write_en)
    );

    always #5 clk = ~clk;

    // Cycle counter.
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read pixel RAM.
    always @(posedge clk) src_readdata <= src_mem[src_address];

    // Monitor writes and done pulses away from the active edge.
    always @(negedge clk) begin
        if (dest_write_en === 1'b1) begin
            wr_addr_q.push_back(int'(dest_address));
            wr_data_q.push_back(int'(dest_writedata));
            last_wr_cyc = cyc;
        end
        if (done === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt = total_cnt + 1;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            pass_cnt = pass_cnt + 1;
    endtask

    function automatic int got_addr(input int i);
        return (i < wr_addr_q.size()) ? wr_addr_q[i] : 32'hDEAD;
    endfunction

    function automatic int got_data(input int i);
        return (i < wr_data_q.size()) ? wr_data_q[i] : 32'hDEAD;
    endfunction

    // kind 0: all 255, 1: all 0, 2: mixed pattern with 0 and 255 included.
    task automatic load_img(input int base, input int n, input int kind);
        logic [7:0] pix;
        for (int i = 0; i < n; i++) begin
            if (kind == 0)      pix = 8'hFF;
            else if (kind == 1) pix = 8'h00;
            else if (i == 0)    pix = 8'h00;
            else if (i == 1)    pix = 8'hFF;
            else                pix = 8'((i * 37 + 11) % 256);
            src_mem[(base + i) % 4096] = {8'hA5, pix};
        end
    endtask

    // Reference encoder: expected write addresses and data.
    task automatic build_exp(input int rows, input int cols, input int steps,
                             input logic [15:0] sd, input int src, input int dst);
        int n;
        int wn;
        logic [15:0] l;
        logic [15:0] word;
        logic [7:0]  pix;
        n  = rows * cols;
        wn = (n + 15) / 16;
        l  = (sd == 16'h0000) ? 16'hACE1 : sd;
        word = 16'h0000;
        exp_addr_q.delete();
        exp_data_q.delete();
        for (int t = 0; t < steps; t++) begin
            for (int p = 0; p < n; p++) begin
                if (p % 16 == 0) word = 16'h0000;
                pix = src_mem[(src + p) % 4096][7:0];
                word[p % 16] = (pix > l[7:0]);
                if (l[0]) l = (l >> 1) ^ 16'hB400;
                else      l = l >> 1;
                if ((p % 16 == 15) || (p == n - 1)) begin
                    exp_data_q.push_back(int'(word));
                    exp_addr_q.push_back((dst + t * wn + p / 16) % 4096);
                end
            end
        end
    endtask

    task automatic launch(input int rows, input int cols, input int steps,
                          input logic [15:0] sd, input int src, input int dst);
        @(negedge clk);
        wr_addr_q.delete();
        wr_data_q.delete();
        done_cnt           = 0;
        row_size           = 6'(rows);
        col_size           = 6'(cols);
        num_steps          = 4'(steps);
        seed               = sd;
        src_start_address  = 12'(src);
        dest_start_address = 12'(dst);
        start              = 1'b1;
        start_cyc          = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait for done; optionally fire a disruptive start mid-run.
    task automatic wait_done(input string tag, input int inject);
        int n;
        n = 0;
        while (done_cnt == 0 && n < 3000) begin
            @(posedge clk);
            #2;
            n = n + 1;
            if (inject > 0 && n == inject) begin
                start              = 1'b1;
                seed               = 16'h5555;
                num_steps          = 4'd0;
                row_size           = 6'd1;
                dest_start_address = 12'h010;
            end else begin
                start = 1'b0;
            end
        end
        check({tag, " done seen"}, 32'(done_cnt != 0), 32'd1);
        repeat (6) @(negedge clk);
    endtask

    task automatic verify(input string tag);
        check({tag, " writes"}, wr_addr_q.size(), exp_addr_q.size());
        for (int i = 0; i < exp_addr_q.size(); i++) begin
            check($sformatf("%s addr%0d", tag, i), got_addr(i), exp_addr_q[i]);
            check($sformatf("%s data%0d", tag, i), got_data(i), exp_data_q[i]);
        end
        check({tag, " done count"}, done_cnt, 1);
        if (exp_addr_q.size() > 0)
            check({tag, " done after write"}, done_cyc - last_wr_cyc, 1);
        else
            check({tag, " done after start"}, done_cyc - start_cyc, 1);
        check({tag, " busy idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        start = 1'b0;
        row_size = 6'd0;
        col_size = 6'd0;
        num_steps = 4'd0;
        seed = 16'h0000;
        src_start_address = 12'h000;
        dest_start_address = 12'h000;
        for (int i = 0; i < 4096; i++) src_mem[i] = 16'h5A00;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst done", 32'(done), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst wen", 32'(dest_write_en), 32'd0);
        check("rst wdata", 32'(dest_writedata), 32'd0);
        check("rst saddr", 32'(src_address), 32'd0);
        check("rst daddr", 32'(dest_address), 32'd0);
        reset = 1'b0;

        // 3x3 all 255, seed 1, one step: hand value 0x01FF.
        load_img(12'h000, 9, 0);
        build_exp(3, 3, 1, 16'h0001, 12'h000, 12'h100);
        launch(3, 3, 1, 16'h0001, 12'h000, 12'h100);
        check("r034 busy", 32'(busy), 32'd1);
        wait_done("r034", 0);
        verify("r034");
        check("r034 hand data", got_data(0), 32'h01FF);
        check("r034 hand addr", got_addr(0), 32'h100);

        // 4x4 all zero, three steps.
        load_img(12'h020, 16, 1);
        build_exp(4, 4, 3, 16'h1234, 12'h020, 12'h200);
        launch(4, 4, 3, 16'h1234, 12'h020, 12'h200);
        wait_done("r035", 0);
        verify("r035");
        check("r035 hand addr2", got_addr(2), 32'h202);
        check("r035 hand data1", got_data(1), 32'h0000);

        // 5x5 mixed, two steps, seed 0 selects the default seed.
        load_img(12'h040, 25, 2);
        build_exp(5, 5, 2, 16'h0000, 12'h040, 12'h300);
        launch(5, 5, 2, 16'h0000, 12'h040, 12'h300);
        wait_done("r036", 0);
        verify("r036");
        check("r036 w1 high bits", got_data(1) >> 9, 32'd0);
        check("r036 w3 high bits", got_data(3) >> 9, 32'd0);
        check("r036 hand addr3", got_addr(3), 32'h303);

        // num_steps = 0.
        build_exp(5, 5, 0, 16'h0001, 12'h040, 12'h400);
        launch(5, 5, 0, 16'h0001, 12'h040, 12'h400);
        check("r037 busy", 32'(busy), 32'd0);
        wait_done("r037", 0);
        verify("r037");

        // Reset during the third READ, then a clean rerun.
        load_img(12'h300, 25, 2);
        launch(5, 5, 2, 16'hBEEF, 12'h300, 12'h500);
        n = 0;
        while (src_address !== 12'h302 && n < 200) begin
            @(negedge clk);
            n = n + 1;
        end
        check("r038 third read seen", 32'(src_address), 32'h302);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("r038 no writes", wr_addr_q.size(), 0);
        check("r038 busy in reset", 32'(busy), 32'd0);
        check("r038 wen in reset", 32'(dest_write_en), 32'd0);
        reset = 1'b0;
        build_exp(5, 5, 2, 16'hBEEF, 12'h300, 12'h500);
        launch(5, 5, 2, 16'hBEEF, 12'h300, 12'h500);
        wait_done("r038", 0);
        verify("r038");

        // start while busy is ignored; second word address wraps to 0.
        build_exp(5, 5, 1, 16'h1234, 12'h040, 12'hFFF);
        launch(5, 5, 1, 16'h1234, 12'h040, 12'hFFF);
        wait_done("r039", 20);
        verify("r039");
        check("r039 hand addr0", got_addr(0), 32'hFFF);
        check("r039 hand addr1", got_addr(1), 32'h000);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
